// File: rtl/register_stack_if.sv
// Bus bundle for register_stack: stack commands, TOS operations and status.
// REGISTER_STACK_PEEK_EN adds the combinational peek port group.
interface register_stack_if #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] in;
    logic                  cl;
    logic                  inc;
    logic                  dec;
    logic                  sr;
    logic                  ir;
    logic                  sl;
    logic                  il;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] top;
    logic [CNT_W-1:0]      count;
    logic                  empty;
    logic                  full;
    logic                  overflow;
    logic                  underflow;
`ifdef REGISTER_STACK_PEEK_EN
    localparam int IDX_W = $clog2(DEPTH);
    logic [IDX_W-1:0]      peek_idx;
    logic [DATA_WIDTH-1:0] peek_data;
    logic                  peek_valid;
`endif

    modport master (
        output push, pop, in, cl, inc, dec, sr, ir, sl, il, clr_err,
`ifdef REGISTER_STACK_PEEK_EN
        output peek_idx,
        input  peek_data, peek_valid,
`endif
        input  top, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, in, cl, inc, dec, sr, ir, sl, il, clr_err,
`ifdef REGISTER_STACK_PEEK_EN
        input  peek_idx,
        output peek_data, peek_valid,
`endif
        output top, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/register_stack.sv
// LIFO of DATA_WIDTH-bit registers with in-place TOS operations and sticky error flags.
// Optional feature macro: REGISTER_STACK_PEEK_EN (combinational indexed peek).
module register_stack #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input logic             clk,
    input logic             rst,
    register_stack_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        CMD_IDLE,
        CMD_REPLACE,
        CMD_PUSH,
        CMD_POP,
        CMD_TOS
    } cmd_e;

    logic [DATA_WIDTH-1:0] mem_p0 [DEPTH];
    logic [DATA_WIDTH-1:0] top_p0;
    logic [CNT_W-1:0]      count_p0;
    logic                  empty_p0;
    logic                  full_p0;
    logic                  overflow_p0;
    logic                  underflow_p0;

    cmd_e                  cmd;
    logic                  has_tos_op;
    logic                  is_empty;
    logic                  is_full;
    logic [IDX_W-1:0]      tos_idx;
    logic [IDX_W-1:0]      below_idx;
    logic                  wr_en;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] top_d;
    logic [CNT_W-1:0]      count_d;
    logic                  ovf_set;
    logic                  unf_set;

    // Single TOS operation in priority order cl > inc > dec > sr > sl; inc/dec wrap modulo 2^DATA_WIDTH.
    function automatic logic [DATA_WIDTH-1:0] tos_op(
        input logic [DATA_WIDTH-1:0] v,
        input logic                  op_cl,
        input logic                  op_inc,
        input logic                  op_dec,
        input logic                  op_sr,
        input logic                  op_ir,
        input logic                  op_sl,
        input logic                  op_il
    );
        logic [DATA_WIDTH-1:0] r;
        r = v;
        if (op_cl)       r = '0;
        else if (op_inc) r = v + DATA_WIDTH'(1);
        else if (op_dec) r = v - DATA_WIDTH'(1);
        else if (op_sr)  r = {op_ir, v[DATA_WIDTH-1:1]};
        else if (op_sl)  r = {v[DATA_WIDTH-2:0], op_il};
        return r;
    endfunction

    // A fresh error in the same cycle beats clr_err.
    function automatic logic sticky_next(input logic cur, input logic clr, input logic set);
        return set | (cur & ~clr);
    endfunction

    always_comb begin
        is_empty   = (count_p0 == '0);
        is_full    = (count_p0 == CNT_W'(DEPTH));
        tos_idx    = IDX_W'(count_p0 - CNT_W'(1));
        below_idx  = IDX_W'(count_p0 - CNT_W'(2));
        has_tos_op = bus.cl | bus.inc | bus.dec | bus.sr | bus.sl;
        if (bus.push && bus.pop) cmd = CMD_REPLACE;
        else if (bus.push)       cmd = CMD_PUSH;
        else if (bus.pop)        cmd = CMD_POP;
        else if (has_tos_op)     cmd = CMD_TOS;
        else                     cmd = CMD_IDLE;
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = tos_idx;
        wr_data = bus.in;
        top_d   = top_p0;
        count_d = count_p0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case (cmd)
            CMD_REPLACE: begin
                // Replace on an empty stack degenerates into a push into slot 0.
                wr_en = 1'b1;
                top_d = bus.in;
                if (is_empty) begin
                    wr_idx  = '0;
                    count_d = CNT_W'(1);
                end
            end
            CMD_PUSH: begin
                if (is_full) begin
                    ovf_set = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_idx  = IDX_W'(count_p0);
                    count_d = count_p0 + CNT_W'(1);
                    top_d   = bus.in;
                end
            end
            CMD_POP: begin
                if (is_empty) begin
                    unf_set = 1'b1;
                end else begin
                    count_d = count_p0 - CNT_W'(1);
                    top_d   = (count_p0 >= CNT_W'(2)) ? mem_p0[below_idx] : '0;
                end
            end
            CMD_TOS: begin
                if (!is_empty) begin
                    wr_en   = 1'b1;
                    wr_data = tos_op(top_p0, bus.cl, bus.inc, bus.dec, bus.sr, bus.ir, bus.sl, bus.il);
                    top_d   = wr_data;
                end
            end
            default: ;
        endcase
    end

    // Stage p0: control and the registered TOS copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            top_p0       <= '0;
            count_p0     <= '0;
            empty_p0     <= 1'b1;
            full_p0      <= 1'b0;
            overflow_p0  <= 1'b0;
            underflow_p0 <= 1'b0;
        end else begin
            top_p0       <= top_d;
            count_p0     <= count_d;
            empty_p0     <= (count_d == '0);
            full_p0      <= (count_d == CNT_W'(DEPTH));
            overflow_p0  <= sticky_next(overflow_p0, bus.clr_err, ovf_set);
            underflow_p0 <= sticky_next(underflow_p0, bus.clr_err, unf_set);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem_p0[wr_idx] <= wr_data;
    end

    assign bus.top       = top_p0;
    assign bus.count     = count_p0;
    assign bus.empty     = empty_p0;
    assign bus.full      = full_p0;
    assign bus.overflow  = overflow_p0;
    assign bus.underflow = underflow_p0;

`ifdef REGISTER_STACK_PEEK_EN
    logic             peek_hit;
    logic [IDX_W-1:0] peek_slot;

    always_comb begin
        peek_hit       = (CNT_W'(bus.peek_idx) < count_p0);
        peek_slot      = IDX_W'(count_p0 - CNT_W'(1) - CNT_W'(bus.peek_idx));
        bus.peek_valid = peek_hit;
        bus.peek_data  = peek_hit ? mem_p0[peek_slot] : '0;
    end
`endif

endmodule
